// File: rtl/lane_striper.sv
// Round-robin word striper: gathers one word per active lane into a stripe group
// and presents the whole group to the lane serialisers in one registered cycle.
module lane_striper #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int CNT_W  = $clog2(LANES) + 1
) (
  input  logic                      clk_2f,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      valid_in,
  input  logic                      flush_in,
  input  logic [CNT_W-1:0]          active_lanes,
  output logic [LANES*DATA_W-1:0]   lane_data,
  output logic [LANES-1:0]          lane_valid,
  output logic                      group_valid,
  output logic                      group_partial,
  output logic                      cfg_err
);

  localparam int PTR_W = $clog2(LANES);

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        act_q, act_d;
  logic [DATA_W-1:0]       stage_q [LANES];
  logic [DATA_W-1:0]       stage_d [LANES];
  logic [LANES-1:0]        fill_q, fill_d;

  logic [LANES*DATA_W-1:0] lane_data_q, lane_data_d;
  logic [LANES-1:0]        lane_valid_q, lane_valid_d;
  logic                    group_valid_q, group_valid_d;
  logic                    group_partial_q, group_partial_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    illegal;
  logic [CNT_W-1:0]        san;
  logic [CNT_W-1:0]        eff;
  logic                    complete;
  logic                    flush_now;

  always_comb begin
    illegal = (active_lanes == '0) || (active_lanes > CNT_W'(LANES));
    san     = illegal ? CNT_W'(LANES) : active_lanes;
    eff     = (ptr_q == '0) ? san : act_q;

    ptr_d    = ptr_q;
    act_d    = act_q;
    stage_d  = stage_q;
    fill_d   = fill_q;
    complete = 1'b0;

    if (valid_in) begin
      stage_d[ptr_q] = data_in;
      fill_d[ptr_q]  = 1'b1;
      if (ptr_q == '0) act_d = eff;
      if (CNT_W'(ptr_q) == eff - CNT_W'(1)) begin
        complete = 1'b1;
        ptr_d    = '0;
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end

    // A flush that coincides with the completing word is an ordinary full group.
    flush_now = flush_in && (|fill_d) && !complete;

    lane_data_d     = '0;
    lane_valid_d    = '0;
    group_valid_d   = 1'b0;
    group_partial_d = 1'b0;
    cfg_err_d       = valid_in && (ptr_q == '0) && illegal;

    if (complete || flush_now) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        lane_data_d[k*DATA_W +: DATA_W] = stage_d[k];
      end
      lane_valid_d    = fill_d;
      group_valid_d   = 1'b1;
      group_partial_d = flush_now;
      // Staging is cleared on emit so unfilled lanes of the next group read zero.
      for (int unsigned k = 0; k < LANES; k++) begin
        stage_d[k] = '0;
      end
      fill_d = '0;
      ptr_d  = '0;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      ptr_q           <= '0;
      act_q           <= CNT_W'(LANES);
      for (int unsigned k = 0; k < LANES; k++) begin
        stage_q[k] <= '0;
      end
      fill_q          <= '0;
      lane_data_q     <= '0;
      lane_valid_q    <= '0;
      group_valid_q   <= 1'b0;
      group_partial_q <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      ptr_q           <= ptr_d;
      act_q           <= act_d;
      stage_q         <= stage_d;
      fill_q          <= fill_d;
      lane_data_q     <= lane_data_d;
      lane_valid_q    <= lane_valid_d;
      group_valid_q   <= group_valid_d;
      group_partial_q <= group_partial_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

  assign lane_data     = lane_data_q;
  assign lane_valid    = lane_valid_q;
  assign group_valid   = group_valid_q;
  assign group_partial = group_partial_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_lane_striper.sv
// Bench for lane_striper: a queue-based group model checked every cycle, plus
// hand-computed literal expectations along the directed scenarios.
module tb_lane_striper;

  localparam int W = 32;
  localparam int L = 4;
  localparam int C = 3;

  logic             clk_2f = 1'b0;
  logic             reset;
  logic [W-1:0]     data_in;
  logic             valid_in;
  logic             flush_in;
  logic [C-1:0]     active_lanes;
  logic [L*W-1:0]   lane_data;
  logic [L-1:0]     lane_valid;
  logic             group_valid;
  logic             group_partial;
  logic             cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  lane_striper #(.DATA_W(W), .LANES(L), .CNT_W(C)) dut (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .flush_in(flush_in), .active_lanes(active_lanes), .lane_data(lane_data),
    .lane_valid(lane_valid), .group_valid(group_valid),
    .group_partial(group_partial), .cfg_err(cfg_err)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: words held for the current group, and the group size chosen by its first word.
  logic [W-1:0]   held [$];
  int             grp_n = L;
  logic [L*W-1:0] exp_data = '0;
  logic [L-1:0]   exp_lv = '0;
  logic           exp_gv = 1'b0, exp_gp = 1'b0, exp_cfg = 1'b0;

  task automatic model_emit(input bit partial);
    exp_data = '0;
    exp_lv   = '0;
    for (int i = 0; i < held.size(); i++) begin
      exp_data[i*W +: W] = held[i];
      exp_lv[i]          = 1'b1;
    end
    exp_gv = 1'b1;
    exp_gp = partial;
    held.delete();
  endtask

  always @(posedge clk_2f) begin
    bit emitted;
    emitted  = 1'b0;
    exp_data = '0; exp_lv = '0; exp_gv = 1'b0; exp_gp = 1'b0; exp_cfg = 1'b0;
    if (reset) begin
      held.delete();
      grp_n = L;
    end else begin
      if (valid_in) begin
        if (held.size() == 0) begin
          if (active_lanes == 0 || int'(active_lanes) > L) begin
            grp_n   = L;
            exp_cfg = 1'b1;
          end else begin
            grp_n = int'(active_lanes);
          end
        end
        held.push_back(data_in);
        if (held.size() == grp_n) begin
          model_emit(1'b0);
          emitted = 1'b1;
        end
      end
      if (!emitted && flush_in && held.size() > 0) model_emit(1'b1);
    end
  end

  always @(negedge clk_2f) begin
    chk("m_lane_data",     lane_data,              exp_data);
    chk("m_lane_valid",    {124'b0, lane_valid},   {124'b0, exp_lv});
    chk("m_group_valid",   {127'b0, group_valid},  {127'b0, exp_gv});
    chk("m_group_partial", {127'b0, group_partial},{127'b0, exp_gp});
    chk("m_cfg_err",       {127'b0, cfg_err},      {127'b0, exp_cfg});
  end

  // Drive one cycle of inputs at a negedge; return at the next negedge with outputs settled.
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit f);
    valid_in = v; data_in = d; flush_in = f;
    @(negedge clk_2f);
    valid_in = 1'b0; flush_in = 1'b0; data_in = '0;
  endtask

  task automatic lit(input string name, input logic [L*W-1:0] d, input logic [L-1:0] lv,
                     input bit gv, input bit gp);
    chk({name, "_data"}, lane_data, d);
    chk({name, "_lv"},   {124'b0, lane_valid}, {124'b0, lv});
    chk({name, "_gv"},   {127'b0, group_valid}, {127'b0, gv});
    chk({name, "_gp"},   {127'b0, group_partial}, {127'b0, gp});
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; flush_in = 1'b0; data_in = '0; active_lanes = 3'd4;
    @(negedge clk_2f);
    @(negedge clk_2f);
    lit("reset", '0, 4'h0, 1'b0, 1'b0);
    chk("reset_cfg", {127'b0, cfg_err}, 128'd0);
    reset = 1'b0;

    // full group of four
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hA0 + i, 1'b0);
    lit("grpA", {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, 1'b1, 1'b0);

    // idle cycles leave no gaps
    cyc(1'b1, 32'hB0, 1'b0); lit("gapB0", '0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 32'hB1, 1'b0);
    cyc(1'b1, 32'hB2, 1'b0); lit("gapB2", '0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b1, 32'hB3, 1'b0);
    lit("grpB", {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'hF, 1'b1, 1'b0);

    // two active lanes
    active_lanes = 3'd2;
    for (int i = 0; i < 6; i += 2) begin
      cyc(1'b1, 32'hC0 + i, 1'b0);
      lit("c_even", '0, 4'h0, 1'b0, 1'b0);
      cyc(1'b1, 32'hC1 + i, 1'b0);
    end
    lit("grpC2", {32'h0, 32'h0, 32'hC5, 32'hC4}, 4'h3, 1'b1, 1'b0);

    // flush of a partial group, then a word lands in lane 0
    active_lanes = 3'd4;
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hD0 + i, 1'b0);
    cyc(1'b0, '0, 1'b1);
    lit("flushD", {32'h0, 32'hD2, 32'hD1, 32'hD0}, 4'h7, 1'b1, 1'b1);
    cyc(1'b1, 32'hF0, 1'b1);
    lit("flushF", {32'h0, 32'h0, 32'h0, 32'hF0}, 4'h1, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b1);
    lit("flush_empty", '0, 4'h0, 1'b0, 1'b0);

    // reset mid-group discards held words
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h12, 1'b0);
    reset = 1'b1; cyc(1'b0, '0, 1'b0); reset = 1'b0;
    lit("rst_mid", '0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'hE0 + i, 1'b0);
    lit("grpE", {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 4'hF, 1'b1, 1'b0);

    // illegal count 0 -> four lanes; mid-group change ignored
    active_lanes = 3'd0;
    cyc(1'b1, 32'h60, 1'b0);
    chk("cfg0_pulse", {127'b0, cfg_err}, 128'd1);
    active_lanes = 3'd1;
    for (int i = 1; i < 4; i++) cyc(1'b1, 32'h60 + i, 1'b0);
    chk("cfg0_clear", {127'b0, cfg_err}, 128'd0);
    lit("grpG", {32'h63, 32'h62, 32'h61, 32'h60}, 4'hF, 1'b1, 1'b0);

    // one lane: a group every cycle
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h70 + i, 1'b0);
      lit("eff1", {96'h0, 32'h70 + i}, 4'h1, 1'b1, 1'b0);
    end

    // illegal count above LANES
    active_lanes = 3'd5;
    cyc(1'b1, 32'h80, 1'b0);
    chk("cfg5_pulse", {127'b0, cfg_err}, 128'd1);
    for (int i = 1; i < 4; i++) cyc(1'b1, 32'h80 + i, 1'b0);
    lit("grp5", {32'h83, 32'h82, 32'h81, 32'h80}, 4'hF, 1'b1, 1'b0);

    // flush together with the completing word is a full group
    active_lanes = 3'd2;
    cyc(1'b1, 32'h90, 1'b0);
    cyc(1'b1, 32'h91, 1'b1);
    lit("flush_full", {32'h0, 32'h0, 32'h91, 32'h90}, 4'h3, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0);
    lit("idle_end", '0, 4'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
